inst_fetch: RTL

Instruction fetch stage of the RISC-V core. Holds the PC and drives the synchronous-read instruction memory (one-cycle read latency). Presents the fetched instruction, its PC and the pre-sliced opcode/func3/func2 fields to the control decoder. Absorbs decode stalls without refetching and accepts redirects from execute.

---
 rtl/inst_fetch_pkg.sv | 20 ++
 rtl/fetch_hold_reg.sv | 26 ++
 rtl/inst_fetch.sv | 122 ++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared core pipeline constants for the fetch stage: reset PC, JAL opcode,
// fetch FSM encoding and the J-type immediate helper.
package inst_fetch_pkg;

    localparam int          CORE_DWIDTH      = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;
    localparam logic [6:0]  OPC_JAL          = 7'b110_1111;

    typedef enum logic [1:0] {
        FETCH_EMPTY  = 2'd0,
        FETCH_STREAM = 2'd1,
        FETCH_HOLD   = 2'd2
    } fetch_state_e;

    // J-type immediate: inst[31|19:12|20|30:21] scaled by 2, sign-extended.
    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Parking register for an instruction that decode could not accept.
// Captures the streaming IMEM word on a stall and is cleared on redirect/reset.
module fetch_hold_reg #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] hold_inst
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    // NOTE: this is a single datapath register, so resetting it is cheap and
    // keeps the held word deterministic; a wide array would not be reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hold_inst <= '0;
        end else if (capture) begin
            hold_inst <= din;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC sequencing, stall absorption and redirects.
// Optional static JAL prediction is enabled with `define INST_FETCH_STATIC_PRED_EN.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                DWIDTH   = CORE_DWIDTH,
    parameter logic [DWIDTH-1:0] RESET_PC = DWIDTH'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic [DWIDTH-1:0] imem_dout,
    input  logic              dec_stall,
    input  logic              redirect_valid,
    input  logic [DWIDTH-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DWIDTH-1:0] if_pc,
    output logic [DWIDTH-1:0] if_inst,
    output logic [6:0]        if_opcode,
    output logic [2:0]        if_func3,
    output logic              if_func2,
    output logic              if_pred_taken
);

    localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);

    fetch_state_e      state_q, state_d;
    logic [DWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] hold_inst;
    logic [DWIDTH-1:0] redirect_tgt;
    logic              hold_capture;
    logic              hold_clear;

    assign redirect_tgt = {redirect_pc[DWIDTH-1:2], 2'b00};

    fetch_hold_reg #(
        .DWIDTH (DWIDTH)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .capture   (hold_capture),
        .clear     (hold_clear),
        .din       (imem_dout),
        .hold_inst (hold_inst)
    );

    // Output side: a parked word has priority over the live IMEM response.
    assign if_inst   = (state_q == FETCH_HOLD) ? hold_inst : imem_dout;
    assign if_pc     = pc_q;
    assign if_valid  = !rst && !redirect_valid && (state_q != FETCH_EMPTY);
    assign if_opcode = if_inst[6:0];
    assign if_func3  = if_inst[14:12];
    assign if_func2  = if_inst[30];

`ifdef INST_FETCH_STATIC_PRED_EN
    logic              pred_take;
    logic [DWIDTH-1:0] pred_tgt;

    // Only an instruction decode is actually consuming this cycle may steer fetch.
    assign pred_take     = if_valid && !dec_stall && (if_opcode == OPC_JAL);
    assign pred_tgt      = pc_q + j_imm(if_inst);
    assign if_pred_taken = pred_take;
`else
    assign if_pred_taken = 1'b0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path
    // through the priority chain can infer a latch.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pc_d         = pc_q;
        imem_addr    = fetch_pc_q;
        hold_capture = 1'b0;
        hold_clear   = 1'b0;

        if (rst) begin
            state_d    = FETCH_EMPTY;
            fetch_pc_d = RESET_PC;
            pc_d       = RESET_PC;
            imem_addr  = RESET_PC;
            hold_clear = 1'b1;
        end else if (redirect_valid) begin
            imem_addr  = redirect_tgt;
            pc_d       = redirect_tgt;
            fetch_pc_d = redirect_tgt + PC_STEP;
            state_d    = FETCH_STREAM;
            hold_clear = 1'b1;
`ifdef INST_FETCH_STATIC_PRED_EN
        end else if (pred_take) begin
            imem_addr  = pred_tgt;
            pc_d       = pred_tgt;
            fetch_pc_d = pred_tgt + PC_STEP;
            state_d    = FETCH_STREAM;
`endif
        end else if (dec_stall) begin
            // The request issued this cycle is a throwaway; fetch_pc reissues it on release.
            if (state_q == FETCH_STREAM) begin
                hold_capture = 1'b1;
                state_d      = FETCH_HOLD;
            end
        end else begin
            pc_d       = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = FETCH_STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_EMPTY;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
        end
    end

endmodule
